// File: rtl/sync_fifo_param.sv
// ----------------------------------------------------------------------------
// sync_fifo_param
//   Parametrised single-clock FIFO with occupancy count, programmable
//   almost-full / almost-empty thresholds and a choice of standard
//   (registered, one-cycle read latency) or first-word-fall-through read.
//
// Parameters
//   DATA_WIDTH    : width of data_in / data_out (>= 1)
//   DEPTH         : number of entries (>= 2, need not be a power of two)
//   AFULL_THRESH  : almostfull  when count >= AFULL_THRESH  (1 .. DEPTH)
//   AEMPTY_THRESH : almostempty when count <= AEMPTY_THRESH (0 .. DEPTH-1)
//   FWFT          : 0 = standard read, 1 = first-word-fall-through
//
// Ports
//   clk         : clock, rising edge
//   rst         : synchronous reset, active-high
//   wr_en       : write request
//   data_in     : write data
//   rd_en       : read request (FWFT: pop the head word)
//   data_out    : read data
//   full        : count == DEPTH
//   empty       : count == 0
//   almostfull  : count >= AFULL_THRESH
//   almostempty : count <= AEMPTY_THRESH
//   count       : current occupancy
//   wr_ack      : previous-cycle write was accepted
//   overflow    : previous-cycle write was rejected
//   underflow   : previous-cycle read was rejected
// ----------------------------------------------------------------------------
module sync_fifo_param #(
    parameter int DATA_WIDTH    = 16,
    parameter int DEPTH         = 8,
    parameter int AFULL_THRESH  = DEPTH - 1,
    parameter int AEMPTY_THRESH = 1,
    parameter int FWFT          = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [DATA_WIDTH-1:0]      data_in,
    input  logic                       rd_en,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       full,
    output logic                       empty,
    output logic                       almostfull,
    output logic                       almostempty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       wr_ack,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AF    = CNT_W'(AFULL_THRESH);
    localparam logic [CNT_W-1:0] CNT_AE    = CNT_W'(AEMPTY_THRESH);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);

    // Reject unusable configurations while elaborating.
    if (DEPTH < 2) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be >= 2");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
        $error("sync_fifo_param: AFULL_THRESH must be in 1..DEPTH");
    end
    if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
        $error("sync_fifo_param: AEMPTY_THRESH must be in 0..DEPTH-1");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0]      wr_ptr_q,    wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q,    rd_ptr_d;
    logic [CNT_W-1:0]      count_q,     count_d;
    logic [DATA_WIDTH-1:0] data_out_q,  data_out_d;
    logic                  wr_ack_q,    wr_ack_d;
    logic                  overflow_q,  overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  rd_acc;
    logic                  wr_acc;

    // Flags are pure decodes of the registered count.
    assign full        = (count_q == CNT_DEPTH);
    assign empty       = (count_q == '0);
    assign almostfull  = (count_q >= CNT_AF);
    assign almostempty = (count_q <= CNT_AE);
    assign count       = count_q;
    assign wr_ack      = wr_ack_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

    // FWFT presents the head word directly; standard mode shows the last
    // word popped and holds it.
    assign data_out = (FWFT != 0) ? (empty ? '0 : mem[rd_ptr_q]) : data_out_q;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        rd_acc      = rd_en && !empty;
        // A full FIFO still takes a write when a read frees a slot this cycle.
        wr_acc      = wr_en && (!full || rd_acc);
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        data_out_d  = data_out_q;
        wr_ack_d    = wr_acc;
        overflow_d  = wr_en && !wr_acc;
        underflow_d = rd_en && !rd_acc;

        // Explicit wrap keeps non-power-of-two depths correct.
        if (wr_acc) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
        end
        if (rd_acc) begin
            rd_ptr_d   = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
            data_out_d = mem[rd_ptr_q];
        end

        if (wr_acc && !rd_acc) begin
            count_d = count_q + CNT_ONE;
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            wr_ack_q    <= wr_ack_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers and
    // count make stale contents unreachable, and leaving it out lets the
    // array map onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_acc && !rst) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

endmodule
